vga_timing_pattern_gen: RTL
===========================

Name: vga_timing_pattern_gen

Overview:
Parametrised VGA sync and test-pattern generator, the successor to the fixed 640x480 VGA_Module.
- Generates hs/vs/de from a system clock through an internal pixel-clock enable.
- Timing, colour depth, sync polarity and clock divide ratio are all configurable.
- Drives Red/Green/Blue from one of four runtime-selectable sources: colour bars, checkerboard, solid colour or external pixel input.
- Sits between the pixel source (game/white-balance logic) and the board VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 4, system clocks per pixel (>=1); 100 MHz -> 25 MHz
COLOR_W, 4, bits per colour channel
HS_POL, 0, active level of hs
VS_POL, 0, active level of vs
CHECK_LOG2, 5, checkerboard square size = 2^CHECK_LOG2 pixels

Ports:
clock  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = run; 0 = synchronous clear of counters, outputs blanked
mode  in  2  0 bars, 1 checker, 2 solid, 3 external
solid_rgb  in  3*COLOR_W  {R,G,B} for mode 2
ext_rgb  in  3*COLOR_W  {R,G,B} for mode 3; sampled on pix_ce
pixel_x  out  clog2(H_TOTAL)  current horizontal count (combinational from counter)
pixel_y  out  clog2(V_TOTAL)  current vertical count
pix_ce  out  1  pixel clock enable, one clock wide
frame_start  out  1  one-clock pulse, see Behaviour
de  out  1  registered data enable
hs  out  1  horizontal sync
vs  out  1  vertical sync
Red/Green/Blue  out  COLOR_W each  pixel colour

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Reset values (rst_n low, asynchronous):
  - div, h_cnt, v_cnt = 0.
  - hs = ~HS_POL; vs = ~VS_POL.
  - de = 0; RGB = 0; frame_start = 0.
  - Latched mode = 0.
- Divider div counts 0..CLK_DIV-1. pix_ce = 1 while div == CLK_DIV-1. With CLK_DIV = 1, pix_ce is constantly 1 out of reset.
- On pix_ce:
  - h_cnt increments and wraps H_TOTAL-1 -> 0.
  - On that wrap, v_cnt increments and wraps V_TOTAL-1 -> 0.
- Registered outputs update only on pix_ce, from the pre-increment counters (latency 1 pixel; hs, vs, de and RGB stay mutually aligned).
- Active region: active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE). de <= active.
- hs <= HS_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL. vs uses the same rule on v_cnt.
- RGB <= 0 when not active.
- Mode latch: mode is sampled only on a pix_ce with h_cnt == 0 and v_cnt == 0. A mid-frame change takes effect at the next frame, so no tearing.
- frame_start = 1 for exactly the clock on which that pix_ce occurs.
- Colour bars (mode 0):
  - BAR_W = H_ACTIVE/8. Order: white, yellow, cyan, green, magenta, red, blue, black.
  - Full-scale channel = all ones.
  - Pixels at h_cnt >= 8*BAR_W are black.
  - Bar index comes from a bar-position counter reset at h_cnt == 0. No divider.
- Checkerboard (mode 1): white when h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2], else black.
- Solid (mode 2): RGB <= solid_rgb. External (mode 3): RGB <= ext_rgb.
- The external source receives pixel_x/pixel_y and must hold ext_rgb valid at the pix_ce of that pixel.
- enable low:
  - div, h_cnt, v_cnt cleared to 0 and held.
  - de = 0, RGB = 0, syncs inactive, pix_ce = 0, frame_start = 0.
  - On enable rising, the divider restarts from 0. The first pix_ce comes CLK_DIV clocks later and carries frame_start.
- Reset mid-frame: all state returns to reset values at once, with no partial-line completion.

Decomposition:
- Package vga_pkg holds:
  - Mode constants MODE_BARS/MODE_CHECK/MODE_SOLID/MODE_EXT.
  - The 8-entry bar colour order as 3-bit RGB masks.
  - Default 640x480@60 timing constants.
- Sub-module vga_pattern_src: combinational per-pixel colour from (h_cnt, v_cnt, bar index, latched mode, solid_rgb, ext_rgb).
- The top level keeps the divider, counters, sync decode and output registers.

Test Plan:
Small bench config: H 16/2/3/3 (total 24), V 8/1/2/1 (total 12), CLK_DIV = 2, COLOR_W = 4, checker size 4.
- Reset then run:
  - pix_ce every 2nd clock.
  - hs low for exactly 3 pixels starting 1 pixel after h_cnt = 18.
  - vs low for lines 9-10.
  - Frame = 24*12*2 = 576 clocks between frame_start pulses.
- Mode 0:
  - Line 0 de high for 16 pixels.
  - RGB sequence in 2-pixel bars: F/F/F, F/F/0, 0/F/F, 0/F/0, F/0/F, F/0/0, 0/0/F, 0/0/0.
  - RGB = 0 during blanking.
- mode switched 0 -> 2 (solid_rgb = 0x5A3) at line 3: bars persist to frame end; next frame all active pixels = 5/A/3.
- Mode 1: pixel (4,0) white, (0,0) black, (4,4) black.
- Mode 3 with ext_rgb = {pixel_x[3:0], pixel_y[3:0], 4'h0}: output at pixel (7,2) = 7/2/0, one pixel after the counter shows (7,2).
- enable dropped mid-line for 10 clocks, then raised:
  - Outputs blank and syncs inactive while low.
  - frame_start 2 clocks after rise; counters restart at (0,0).
- rst_n asserted mid-frame for a half-clock asynchronously: all outputs take reset values immediately.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA timing / test-pattern generator.
// Bar colours are 3-bit {R,G,B} masks that get widened to full-scale channels.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_SOLID = 2'd2,
    MODE_EXT   = 2'd3
  } vga_mode_e;

  // 640x480@60 with a 25 MHz pixel clock
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int          BAR_COUNT = 8;
  localparam logic [3:0]  BAR_PAST  = 4'd8;

  // Order: white, yellow, cyan, green, magenta, red, blue, black
  function automatic logic [2:0] bar_mask(input logic [3:0] idx);
    logic [2:0] m;
    case (idx)
      4'd0:    m = 3'b111;
      4'd1:    m = 3'b110;
      4'd2:    m = 3'b011;
      4'd3:    m = 3'b010;
      4'd4:    m = 3'b101;
      4'd5:    m = 3'b100;
      4'd6:    m = 3'b001;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/vga_pattern_src.sv
// Combinational colour for the pixel currently addressed by the counters.
// Blanking is applied by the caller; this block only picks the source.
module vga_pattern_src
  import vga_pkg::*;
#(
  parameter int COLOR_W = 4
) (
  input  vga_mode_e              i_mode,
  input  logic [3:0]             i_bar_idx,
  input  logic                   i_check_h,
  input  logic                   i_check_v,
  input  logic [3*COLOR_W-1:0]   i_solid_rgb,
  input  logic [3*COLOR_W-1:0]   i_ext_rgb,
  output logic [3*COLOR_W-1:0]   o_rgb
);

  logic [2:0] w_mask;

  always_comb begin
    o_rgb  = '0;
    w_mask = bar_mask(i_bar_idx);
    case (i_mode)
      MODE_BARS:  o_rgb = {{COLOR_W{w_mask[2]}}, {COLOR_W{w_mask[1]}}, {COLOR_W{w_mask[0]}}};
      MODE_CHECK: o_rgb = (i_check_h ^ i_check_v) ? '1 : '0;
      MODE_SOLID: o_rgb = i_solid_rgb;
      default:    o_rgb = i_ext_rgb;
    endcase
  end

endmodule

// File: rtl/vga_timing_pattern_gen.sv
// Parametrised VGA sync + test-pattern generator driven by a pixel-clock enable.
// Registered outputs describe the pixel the counters held one pix_ce earlier.
module vga_timing_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int CLK_DIV    = 4,
  parameter int COLOR_W    = 4,
  parameter int HS_POL     = 0,
  parameter int VS_POL     = 0,
  parameter int CHECK_LOG2 = 5
) (
  input  logic                                                   clock,
  input  logic                                                   rst_n,
  input  logic                                                   enable,
  input  logic [1:0]                                             mode,
  input  logic [3*COLOR_W-1:0]                                   solid_rgb,
  input  logic [3*COLOR_W-1:0]                                   ext_rgb,
  output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]           pixel_x,
  output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]           pixel_y,
  output logic                                                   pix_ce,
  output logic                                                   frame_start,
  output logic                                                   de,
  output logic                                                   hs,
  output logic                                                   vs,
  output logic [COLOR_W-1:0]                                     Red,
  output logic [COLOR_W-1:0]                                     Green,
  output logic [COLOR_W-1:0]                                     Blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW3     = 3 * COLOR_W;
  localparam int BAR_W   = H_ACTIVE / BAR_COUNT;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] BAR_LAST = HW'(BAR_W - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          HS_ON    = 1'(HS_POL);
  localparam logic          VS_ON    = 1'(VS_POL);

  logic [DW-1:0]  r_div;
  logic [HW-1:0]  r_h;
  logic [VW-1:0]  r_v;
  logic [HW-1:0]  r_bar_cnt;
  logic [3:0]     r_bar_idx;
  logic           r_de;
  logic           r_hs;
  logic           r_vs;
  logic [CW3-1:0] r_rgb;
  vga_mode_e      r_mode;

  logic           w_pix_ce;
  logic           w_frame_start;
  logic           w_active;
  logic           w_hs_on;
  logic           w_vs_on;
  vga_mode_e      w_mode_eff;
  logic [CW3-1:0] w_pat_rgb;

  assign w_pix_ce      = rst_n && enable && (r_div == DIV_LAST);
  assign w_frame_start = w_pix_ce && (r_h == '0) && (r_v == '0);
  assign w_active      = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_hs_on       = (r_h >= HS_BEG) && (r_h < HS_END);
  assign w_vs_on       = (r_v >= VS_BEG) && (r_v < VS_END);
  // The first pixel of a frame already uses the newly sampled mode
  assign w_mode_eff    = w_frame_start ? vga_mode_e'(mode) : r_mode;

  // Divider, raster counters and the bar-position tracker that follows h
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_div     <= '0;
      r_h       <= '0;
      r_v       <= '0;
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
    end else if (!enable) begin
      r_div     <= '0;
      r_h       <= '0;
      r_v       <= '0;
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
    end else begin
      r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
      if (w_pix_ce) begin
        if (r_h == H_LAST) begin
          r_h       <= '0;
          r_bar_cnt <= '0;
          r_bar_idx <= '0;
          r_v       <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
        end else begin
          r_h <= r_h + 1'b1;
          if (r_bar_cnt == BAR_LAST) begin
            r_bar_cnt <= '0;
            if (r_bar_idx != BAR_PAST) r_bar_idx <= r_bar_idx + 1'b1;
          end else begin
            r_bar_cnt <= r_bar_cnt + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_de   <= 1'b0;
      r_hs   <= ~HS_ON;
      r_vs   <= ~VS_ON;
      r_rgb  <= '0;
      r_mode <= MODE_BARS;
    end else if (!enable) begin
      r_de  <= 1'b0;
      r_hs  <= ~HS_ON;
      r_vs  <= ~VS_ON;
      r_rgb <= '0;
    end else if (w_pix_ce) begin
      r_de  <= w_active;
      r_hs  <= w_hs_on ? HS_ON : ~HS_ON;
      r_vs  <= w_vs_on ? VS_ON : ~VS_ON;
      r_rgb <= w_active ? w_pat_rgb : '0;
      if (w_frame_start) r_mode <= vga_mode_e'(mode);
    end
  end

  vga_pattern_src #(
    .COLOR_W (COLOR_W)
  ) u_src (
    .i_mode      (w_mode_eff),
    .i_bar_idx   (r_bar_idx),
    .i_check_h   (r_h[CHECK_LOG2]),
    .i_check_v   (r_v[CHECK_LOG2]),
    .i_solid_rgb (solid_rgb),
    .i_ext_rgb   (ext_rgb),
    .o_rgb       (w_pat_rgb)
  );

  assign pixel_x     = r_h;
  assign pixel_y     = r_v;
  assign pix_ce      = w_pix_ce;
  assign frame_start = w_frame_start;
  assign de          = r_de;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign Red         = r_rgb[CW3-1 -: COLOR_W];
  assign Green       = r_rgb[2*COLOR_W-1 -: COLOR_W];
  assign Blue        = r_rgb[COLOR_W-1:0];

endmodule
